// File: rtl/tc_tile_issue.sv
// Row-to-tile converter: buffers a full M x N matrix one row at a time, then
// issues it as M_TILE x N_TILE tiles in row-major tile order with tile pointers.
module tc_tile_issue #(
    parameter int unsigned M       = 16,
    parameter int unsigned N       = 16,
    parameter int unsigned M_TILE  = 4,
    parameter int unsigned N_TILE  = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned DW_INT  = 32,
    parameter int unsigned DW_ROW  = DW * N,
    parameter int unsigned DW_TILE = DW * M_TILE * N_TILE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [DW_ROW-1:0]  in_row,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DW_TILE-1:0] out_tile,
    output logic [DW_INT-1:0]  ptr_row,
    output logic [DW_INT-1:0]  ptr_col,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               done
);

    localparam int unsigned RW      = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned CW      = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TROWS   = M / M_TILE;
    localparam int unsigned TCOLS   = N / N_TILE;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                    state_q;
    logic [RW-1:0]             row_cnt_q;
    logic [DW_INT-1:0]         ptr_row_q;
    logic [DW_INT-1:0]         ptr_col_q;
    logic                      done_q;
    logic [N-1:0][DW-1:0]      buf_q [M];

    logic                      row_last_c;
    logic                      col_last_c;

    assign in_ready   = (state_q == ST_LOAD) & enable;
    assign out_valid  = (state_q == ST_ISSUE) & enable;
    assign row_last_c = (ptr_row_q == DW_INT'(TROWS - 1));
    assign col_last_c = (ptr_col_q == DW_INT'(TCOLS - 1));
    assign out_last   = out_valid & row_last_c & col_last_c;
    assign ptr_row    = ptr_row_q;
    assign ptr_col    = ptr_col_q;
    assign done       = done_q;

    // Matrix storage; contents survive reset, only the write pointer is cleared.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            buf_q[row_cnt_q] <= in_row;
        end
    end

    // Control FSM: load rows, issue tiles, pulse done, then reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_LOAD;
            row_cnt_q <= '0;
            ptr_row_q <= '0;
            ptr_col_q <= '0;
            done_q    <= 1'b0;
        end else if (enable) begin
            done_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (in_valid) begin
                        if (row_cnt_q == RW'(M - 1)) begin
                            row_cnt_q <= '0;
                            state_q   <= ST_ISSUE;
                        end else begin
                            row_cnt_q <= row_cnt_q + RW'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        if (row_last_c && col_last_c) begin
                            ptr_row_q <= '0;
                            ptr_col_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else if (col_last_c) begin
                            ptr_col_q <= '0;
                            ptr_row_q <= ptr_row_q + DW_INT'(1);
                        end else begin
                            ptr_col_q <= ptr_col_q + DW_INT'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_LOAD;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    // Tile gather: pure mux from the registered pointers, stable under stall.
    always_comb begin
        out_tile = '0;
        for (int i = 0; i < int'(M_TILE); i++) begin
            for (int j = 0; j < int'(N_TILE); j++) begin
                out_tile[DW*(i*int'(N_TILE)+j) +: DW] =
                    buf_q[RW'(ptr_row_q * DW_INT'(M_TILE) + DW_INT'(i))]
                         [CW'(ptr_col_q * DW_INT'(N_TILE) + DW_INT'(j))];
            end
        end
    end

endmodule

// File: tb/tb_tc_tile_issue.sv
// Directed bench for tc_tile_issue on an 8x8 matrix split into 4x4 tiles.
module tb_tc_tile_issue;

    localparam int unsigned M       = 8;
    localparam int unsigned N       = 8;
    localparam int unsigned MT      = 4;
    localparam int unsigned NT      = 4;
    localparam int unsigned DW      = 32;
    localparam int unsigned DW_INT  = 32;
    localparam int unsigned DW_ROW  = DW * N;
    localparam int unsigned DW_TILE = DW * MT * NT;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic [DW_ROW-1:0]  in_row;
    logic               in_valid;
    logic               in_ready;
    logic [DW_TILE-1:0] out_tile;
    logic [DW_INT-1:0]  ptr_row;
    logic [DW_INT-1:0]  ptr_col;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               done;

    int compared   = 0;
    int mismatched = 0;

    tc_tile_issue #(
        .M(M), .N(N), .M_TILE(MT), .N_TILE(NT), .DW(DW), .DW_INT(DW_INT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .in_row(in_row), .in_valid(in_valid), .in_ready(in_ready),
        .out_tile(out_tile), .ptr_row(ptr_row), .ptr_col(ptr_col),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW_ROW-1:0] make_row(input int base, input int r);
        logic [DW_ROW-1:0] v;
        v = '0;
        for (int c = 0; c < int'(N); c++) v[DW*c +: DW] = DW'(base + r*8 + c);
        return v;
    endfunction

    function automatic logic [DW_TILE-1:0] tile_exp(input int base, input int tr, input int tc);
        logic [DW_TILE-1:0] t;
        t = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[DW*(i*4+j) +: DW] = DW'(base + (tr*4+i)*8 + tc*4 + j);
        return t;
    endfunction

    // Drives eight rows back to back; handshake lands on each following edge.
    task automatic load_rows(input int base);
        for (int r = 0; r < 8; r++) begin
            in_row   = make_row(base, r);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
        #12;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        compared++; if (ptr_row !== 0 || ptr_col !== 0) begin mismatched++; $display("FAIL reset_ptrs: got %0d,%0d want 0,0", ptr_row, ptr_col); end
        compared++; if (done !== 1'b0 || out_last !== 1'b0) begin mismatched++; $display("FAIL reset_done_last: got %b,%b want 0,0", done, out_last); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        load_rows(0);
        for (int t = 0; t < 4; t++) begin
            compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL basic_valid t%0d: got %b want 1", t, out_valid); end
            compared++; if (ptr_row !== t/2 || ptr_col !== t%2) begin mismatched++; $display("FAIL basic_ptr t%0d: got %0d,%0d want %0d,%0d", t, ptr_row, ptr_col, t/2, t%2); end
            compared++; if (out_tile !== tile_exp(0, t/2, t%2)) begin mismatched++; $display("FAIL basic_tile t%0d: got %h want %h", t, out_tile, tile_exp(0, t/2, t%2)); end
            compared++; if (out_last !== (t == 3)) begin mismatched++; $display("FAIL basic_last t%0d: got %b want %b", t, out_last, (t == 3)); end
            compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL basic_done_early t%0d: got %b want 0", t, done); end
            if (t == 3) begin
                compared++; if (out_tile[0 +: DW] !== 36) begin mismatched++; $display("FAIL basic_elem00: got %0d want 36", out_tile[0 +: DW]); end
                compared++; if (out_tile[DW*15 +: DW] !== 63) begin mismatched++; $display("FAIL basic_elem33: got %0d want 63", out_tile[DW*15 +: DW]); end
            end
            step();
        end
        compared++; if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin mismatched++; $display("FAIL basic_done_cycle: got done=%b ov=%b ir=%b want 1,0,0", done, out_valid, in_ready); end
        step();
        compared++; if (done !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL basic_after_done: got done=%b ir=%b want 0,1", done, in_ready); end
    endtask

    task automatic test_backpressure();
        int hs;
        hs = 0;
        out_ready = 1'b0;
        load_rows(0);
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 3; k++) begin
                out_ready = (k == 2);
                #1;
                compared++; if (out_valid !== 1'b1 || ptr_row !== t/2 || ptr_col !== t%2) begin mismatched++; $display("FAIL bp_hold t%0d k%0d: got ov=%b ptr=%0d,%0d want 1,%0d,%0d", t, k, out_valid, ptr_row, ptr_col, t/2, t%2); end
                compared++; if (out_tile !== tile_exp(0, t/2, t%2)) begin mismatched++; $display("FAIL bp_tile t%0d k%0d: got %h want %h", t, k, out_tile, tile_exp(0, t/2, t%2)); end
                if (out_valid && out_ready) hs++;
                step();
            end
        end
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid && out_ready) hs++;
            step();
        end
        compared++; if (hs !== 4) begin mismatched++; $display("FAIL bp_handshakes: got %0d want 4", hs); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_back_to_load: got %b want 1", in_ready); end
    endtask

    task automatic test_gaps();
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int g = 0; g < 2; g++) begin
                in_valid = 1'b0;
                #1;
                compared++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin mismatched++; $display("FAIL gap_wait r%0d: got ir=%b ov=%b want 1,0", r, in_ready, out_valid); end
                step();
            end
            in_row   = make_row(100, r);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL gap_first_latency: got %b want 1", out_valid); end
        compared++; if (out_tile !== tile_exp(100, 0, 0)) begin mismatched++; $display("FAIL gap_tile00: got %h want %h", out_tile, tile_exp(100, 0, 0)); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL gap_back_to_load: got %b want 1", in_ready); end
    endtask

    task automatic test_enable();
        out_ready = 1'b1;
        load_rows(200);
        step();
        step();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            compared++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || ptr_row !== 1 || ptr_col !== 0) begin mismatched++; $display("FAIL en_freeze k%0d: got ov=%b ir=%b ptr=%0d,%0d want 0,0,1,0", k, out_valid, in_ready, ptr_row, ptr_col); end
            step();
        end
        enable = 1'b1;
        #1;
        compared++; if (out_valid !== 1'b1 || ptr_row !== 1 || ptr_col !== 0) begin mismatched++; $display("FAIL en_resume: got ov=%b ptr=%0d,%0d want 1,1,0", out_valid, ptr_row, ptr_col); end
        compared++; if (out_tile !== tile_exp(200, 1, 0)) begin mismatched++; $display("FAIL en_tile10: got %h want %h", out_tile, tile_exp(200, 1, 0)); end
        step();
        step();
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL en_done: got %b want 1", done); end
        enable = 1'b0;
        step();
        step();
        compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL en_done_held: got %b want 1", done); end
        enable = 1'b1;
        step();
        compared++; if (done !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL en_done_release: got done=%b ir=%b want 0,1", done, in_ready); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        load_rows(300);
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_mid_hs: got ov=%b ir=%b want 0,1", out_valid, in_ready); end
        compared++; if (ptr_row !== 0 || ptr_col !== 0) begin mismatched++; $display("FAIL rst_mid_ptrs: got %0d,%0d want 0,0", ptr_row, ptr_col); end
        #2;
        reset_n = 1'b1;
        step();
        load_rows(400);
        compared++; if (out_valid !== 1'b1 || ptr_row !== 0 || ptr_col !== 0) begin mismatched++; $display("FAIL rst_reload_ptr: got ov=%b ptr=%0d,%0d want 1,0,0", out_valid, ptr_row, ptr_col); end
        compared++; if (out_tile !== tile_exp(400, 0, 0)) begin mismatched++; $display("FAIL rst_reload_tile: got %h want %h", out_tile, tile_exp(400, 0, 0)); end
        for (int k = 0; k < 5; k++) step();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        out_ready = 1'b1;
        load_rows(500);
        for (int t = 0; t < 4; t++) begin
            compared++; if (out_tile !== tile_exp(500, t/2, t%2)) begin mismatched++; $display("FAIL b2b_a_tile t%0d: got %h want %h", t, out_tile, tile_exp(500, t/2, t%2)); end
            step();
        end
        if (done === 1'b1) pulses++;
        step();
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_reload_ready: got %b want 1", in_ready); end
        load_rows(900);
        for (int t = 0; t < 4; t++) begin
            compared++; if (out_valid !== 1'b1 || out_tile !== tile_exp(900, t/2, t%2)) begin mismatched++; $display("FAIL b2b_b_tile t%0d: got ov=%b %h want %h", t, out_valid, out_tile, tile_exp(900, t/2, t%2)); end
            step();
        end
        if (done === 1'b1) pulses++;
        step();
        compared++; if (pulses !== 2) begin mismatched++; $display("FAIL b2b_done_pulses: got %0d want 2", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tc_tile_issue.md
Name: tc_tile_issue

Overview:
- Row-to-tile converter for the tensor core: the transmit-side counterpart of the tile-accumulate/row-output path.
- Accepts a full M x N matrix one row per handshake into a local buffer, then issues it as M_TILE x N_TILE tiles tagged with tile coordinates ptr_row/ptr_col.
- Feeds tile-consuming blocks (PE array, psum accumulator) using the same tile packing and pointer convention.

Parameters:
- M, 16, matrix rows; must be a multiple of M_TILE.
- N, 16, matrix columns; must be a multiple of N_TILE.
- M_TILE, 4, tile rows.
- N_TILE, 4, tile columns.
- DW, 32, element width in bits.
- DW_INT, 32, pointer width.
- DW_ROW, DW*N, input row bus width (derived).
- DW_TILE, DW*M_TILE*N_TILE, output tile bus width (derived).

Ports:
- clk  in  1  clock; all logic rises on posedge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  global advance enable; low freezes all state.
- in_row  in  DW_ROW  input row; element c at [DW*c +: DW].
- in_valid  in  1  in_row valid.
- in_ready  out  1  block can accept a row.
- out_tile  out  DW_TILE  tile; element (i,j) at [DW*(i*N_TILE+j) +: DW].
- ptr_row  out  DW_INT  tile row index, 0..M/M_TILE-1.
- ptr_col  out  DW_INT  tile column index, 0..N/N_TILE-1.
- out_valid  out  1  tile, ptr_row and ptr_col valid.
- out_ready  in  1  consumer accepts the tile.
- out_last  out  1  current tile is the final tile of the matrix.
- done  out  1  one-cycle pulse after the last tile handshake.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (reset_n).
- States: LOAD, ISSUE, DONE. Reset enters LOAD with row_cnt=0, ptr_row=0, ptr_col=0, done=0. Buffer contents are not reset.
- Combinational outputs: in_ready = (state==LOAD) & enable. out_valid = (state==ISSUE) & enable. out_last = out_valid & ptr_row==M/M_TILE-1 & ptr_col==N/N_TILE-1.
- LOAD: on in_valid & in_ready, write in_row into buffer row row_cnt and increment row_cnt. When the handshake occurs with row_cnt==M-1, set row_cnt to 0 and go to ISSUE.
- First tile latency: out_valid is asserted on the cycle after the M-th row is accepted.
- out_tile element (i,j) = buffer[(ptr_row*M_TILE+i)*N + ptr_col*N_TILE + j]. It is a combinational mux from registered pointers, so it is stable while out_valid is high.
- ISSUE handshake: out_valid & out_ready completes a tile. Order is row-major over the tile grid: ptr_col increments first; on wrap, ptr_col returns to 0 and ptr_row increments.
- Backpressure: while out_ready is low, the pointers and out_tile hold.
- End of matrix: the handshake on the out_last tile clears both pointers and goes to DONE.
- DONE: done=1 for exactly one cycle, then LOAD. in_ready is 0 in DONE, so there is no row/tile overlap (single buffer).
- enable=0: no state, counter or pointer change. in_ready and out_valid read 0, and done is held at its current value.
- Reset mid-operation: an immediate return to LOAD with counters cleared. A partially loaded or issued matrix is discarded.
- Handshake rules: in_valid is ignored outside LOAD, and out_ready is ignored outside ISSUE. Tile count per matrix is (M/M_TILE)*(N/N_TILE).

Test Plan:
- M=N=8, M_TILE=N_TILE=4, element (r,c) = r*8+c. Load 8 rows with out_ready=1 → 4 tiles in order (0,0),(0,1),(1,0),(1,1). Tile (1,1) element (0,0) is 36 and element (3,3) is 63. out_last only on the 4th tile; done pulses the next cycle; in_ready=1 after that.
- Same matrix, out_ready toggled 1 cycle on / 2 off → each tile holds stable with pointers unchanged across stall cycles, and exactly 4 handshakes occur.
- in_valid gaps (rows on every 3rd cycle) → row_cnt advances only on handshakes, and out_valid rises exactly 1 cycle after the 8th accepted row.
- enable dropped for 5 cycles mid-ISSUE after tile (0,1) → no pointer change and out_valid=0. Tile (1,0) is issued after enable returns.
- reset_n asserted asynchronously after 2 tiles → immediately out_valid=0, in_ready=1, ptr_row=ptr_col=0. A fresh 8-row load issues tile (0,0) from the new data.
- Two back-to-back matrices → done pulses twice. The second matrix's tiles match its own data, with no carry-over from the first.
